// File: rtl/spi.sv
// rtl/spi.sv - bit-serial host to 256x8 SRAM bridge with command/address/data field strobes
module spi #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic sdoM,
   output logic sdoS,
   output logic comload,
   output logic addrload,
   output logic dataload
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_READ
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cmd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_shift;
   logic              r_sdos;
   logic              r_comload;
   logic              r_addrload;
   logic              r_dataload;
   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   // The address including the bit arriving on this edge; used to fetch read data
   // on the same edge that completes the address field.
   logic [ADDR_W-1:0] w_addr_full;
   logic [DATA_W-1:0] w_rd_word;

   assign w_addr_full = {r_addr[ADDR_W-2:0], sdoM};
   assign w_rd_word   = r_mem[w_addr_full];

   assign sdoS     = r_sdos;
   assign comload  = r_comload;
   assign addrload = r_addrload;
   assign dataload = r_dataload;

   // Next-state decode: field sequence CMD -> ADDR -> (DATA -> WRITE | READ) -> CMD.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = S_CMD;
         S_CMD:   w_next = S_ADDR;
         S_ADDR:  if (r_cnt == ADDR_LAST) w_next = r_cmd ? S_DATA : S_READ;
         S_DATA:  if (r_cnt == DATA_LAST) w_next = S_WRITE;
         S_WRITE: w_next = S_CMD;
         S_READ:  if (r_cnt == DATA_LAST) w_next = S_CMD;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Bit counter and field capture; counter restarts whenever the state changes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_cmd  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
         if (r_state == S_CMD)  r_cmd  <= sdoM;
         if (r_state == S_ADDR) r_addr <= w_addr_full;
         if (r_state == S_DATA) r_data <= {r_data[DATA_W-2:0], sdoM};
      end
   end

   // Registered strobes and readout: outputs reflect the state being entered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_comload  <= 1'b0;
         r_addrload <= 1'b0;
         r_dataload <= 1'b0;
         r_sdos     <= 1'b0;
         r_shift    <= '0;
      end else begin
         r_comload  <= (w_next == S_CMD);
         r_addrload <= (w_next == S_ADDR);
         r_dataload <= (w_next == S_DATA);
         if (r_state == S_ADDR && w_next == S_READ) begin
            r_sdos  <= w_rd_word[DATA_W-1];
            r_shift <= w_rd_word << 1;
         end else if (r_state == S_READ) begin
            r_sdos  <= (w_next == S_READ) ? r_shift[DATA_W-1] : 1'b0;
            r_shift <= r_shift << 1;
         end else begin
            r_sdos <= 1'b0;
         end
      end
   end

   // Storage array; not reset so contents survive a reset, and an aborted write never commits.
   always_ff @(posedge clock) begin
      if (r_state == S_WRITE) r_mem[r_addr] <= r_data;
   end

endmodule

// File: tb/tb_spi.sv
// tb/tb_spi.sv - directed self-checking bench for the spi serial-to-SRAM bridge
module tb_spi;

   logic clock;
   logic reset;
   logic sdoM;
   logic sdoS;
   logic comload;
   logic addrload;
   logic dataload;

   int n_checks;
   int n_pass;

   spi dut (
      .clock    (clock),
      .reset    (reset),
      .sdoM     (sdoM),
      .sdoS     (sdoS),
      .comload  (comload),
      .addrload (addrload),
      .dataload (dataload)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Strobes packed as {comload, addrload, dataload}.
   function automatic logic [7:0] strobes();
      return {5'b0, comload, addrload, dataload};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic b);
      @(negedge clock);
      sdoM = b;
   endtask

   task automatic send_cmd_addr(input logic cmd, input logic [7:0] a);
      chk("cmd_strobe", strobes(), 8'b100);
      chk("cmd_sdoS", {7'b0, sdoS}, 8'h00);
      drive(cmd);
      step();
      for (int i = 0; i < 8; i++) begin
         chk("addr_strobe", strobes(), 8'b010);
         drive(a[7-i]);
         step();
      end
   endtask

   task automatic write_txn(input logic [7:0] a, input logic [7:0] d);
      send_cmd_addr(1'b1, a);
      for (int i = 0; i < 8; i++) begin
         chk("data_strobe", strobes(), 8'b001);
         drive(d[7-i]);
         step();
      end
      chk("write_strobe", strobes(), 8'b000);
      chk("write_sdoS", {7'b0, sdoS}, 8'h00);
      drive(1'($urandom));
      step();
   endtask

   task automatic read_txn(input logic [7:0] a, input logic [7:0] exp);
      logic [7:0] got;
      got = 8'h00;
      send_cmd_addr(1'b0, a);
      for (int i = 0; i < 8; i++) begin
         chk("read_strobe", strobes(), 8'b000);
         got = {got[6:0], sdoS};
         drive(1'($urandom));
         step();
      end
      chk("read_byte", got, exp);
      chk("read_end_sdoS", {7'b0, sdoS}, 8'h00);
   endtask

   initial begin
      logic [7:0] wa [4];
      logic [7:0] wd [4];
      logic [7:0] abort_data;
      n_checks = 0;
      n_pass   = 0;
      sdoM     = 1'b0;
      reset    = 1'b0;

      // Outputs held at zero throughout reset.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_strobes", strobes(), 8'b000);
         chk("reset_sdoS", {7'b0, sdoS}, 8'h00);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("idle_strobes", strobes(), 8'b000);
      step();

      // Write 35 to 63, then read it back.
      write_txn(8'd63, 8'd35);
      read_txn(8'd63, 8'd35);

      // Extreme addresses do not alias.
      write_txn(8'd0, 8'hA5);
      write_txn(8'd255, 8'h5A);
      read_txn(8'd0, 8'hA5);
      read_txn(8'd255, 8'h5A);

      // Abort a write of FF to 63 during the 4th data bit.
      abort_data = 8'hFF;
      send_cmd_addr(1'b1, 8'd63);
      for (int i = 0; i < 3; i++) begin
         chk("abort_data_strobe", strobes(), 8'b001);
         drive(abort_data[7-i]);
         step();
      end
      chk("abort_4th_strobe", strobes(), 8'b001);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_strobes", strobes(), 8'b000);
      chk("abort_sdoS", {7'b0, sdoS}, 8'h00);
      sdoM = 1'b1;
      step();
      step();
      chk("abort_hold_strobes", strobes(), 8'b000);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("restart_idle", strobes(), 8'b000);
      step();
      read_txn(8'd63, 8'd35);

      // Alternating write/read, including an overwrite of the same address.
      wa[0] = 8'h12; wd[0] = 8'h3C;
      wa[1] = 8'hC8; wd[1] = 8'hC3;
      wa[2] = 8'h12; wd[2] = 8'h81;
      wa[3] = 8'h7F; wd[3] = 8'h00;
      for (int k = 0; k < 4; k++) begin
         write_txn(wa[k], wd[k]);
         read_txn(wa[k], wd[k]);
      end
      read_txn(8'hC8, 8'hC3);
      read_txn(8'h12, 8'h81);
      chk("final_strobe", strobes(), 8'b100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
